mem_line_mover: RTL and testbench
=================================

Name: mem_line_mover

Overview:
- Line-granular memory-to-memory copy engine; it is the initiator side of the 512-bit line port on the shared data memory (9-bit word address, 16×32-bit words per line, combinational read, write on clock edge).
- Copies line_count consecutive 16-word lines from src_addr to dst_addr with memmove semantics, so overlapping regions are copied correctly.
- Sits between the control unit (start/busy/done/error) and the memory's single address port.

Parameters:
ADDR_W, 9, word address width (512-word memory)
WORD_W, 32, bits per memory word
LINE_WORDS, 16, words per line; address step per line
CNT_W, 6, width of line_count (max 32 lines = full memory)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
start  in  1  command strobe, sampled only in IDLE
src_addr  in  ADDR_W  first source word address
dst_addr  in  ADDR_W  first destination word address
line_count  in  CNT_W  number of lines to copy
busy  out  1  high while a copy is in progress
done  out  1  one-cycle pulse on successful completion
error  out  1  one-cycle pulse on rejected command
mem_address  out  ADDR_W  to memory address
mem_data_to_write  out  LINE_WORDS*WORD_W  to memory write data
mem_write_enable  out  1  to memory write enable
mem_data_from_memory  in  LINE_WORDS*WORD_W  from memory read data (combinational)

Behaviour:
- Reset (rst high at posedge): state IDLE; busy, done, error, mem_write_enable = 0; mem_address = 0; mem_data_to_write = 0; line buffer cleared. rst overrides start.
- States: IDLE, CHECK, READ, WRITE, FIN.
- IDLE: busy = 0, mem_write_enable = 0. On start = 1, latch src, dst and count, then go to CHECK.
- CHECK (one cycle, busy = 1):
  - count == 0: go to FIN; no memory access.
  - src + 16·count > 512 or dst + 16·count > 512 (compute at ≥11-bit width, no wrap): pulse error for one cycle and return to IDLE. No write ever occurs; done is not asserted.
  - Otherwise set direction. dst > src means descending: cur_src = src + 16·(count−1), cur_dst = dst + 16·(count−1), step −16. Else ascending: cur = base, step +16. Go to READ.
- READ: mem_address = cur_src, mem_write_enable = 0. At the posedge, capture mem_data_from_memory into the line buffer, then go to WRITE.
- WRITE: mem_address = cur_dst, mem_data_to_write = line buffer, mem_write_enable = 1 for exactly this cycle. At the posedge, step cur_src/cur_dst and decrement remaining. If remaining becomes 0, go to FIN; else go to READ.
- FIN: done = 1 for one cycle, busy = 0, then go to IDLE.
- Latency: start sampled at edge E0 → done high in the cycle after edge E(2N+2) for N lines. Exactly N write-enable cycles, never two consecutive.
- start while busy: ignored, with no effect on the current copy.
- src == dst: copy still performed (rewrite of identical data).
- Reset mid-operation: next cycle is IDLE with mem_write_enable = 0. Lines already written stay written; no done or error pulse.
- mem_write_enable is never high outside WRITE.

Test Plan:
- Reset: hold rst for 2 cycles with start = 1 → busy/done/error/mem_write_enable all 0, mem_address = 0, no memory change.
- Single line: memory words 0..15 = 0x100..0x10F; start with src = 0, dst = 32, count = 1 → one write at address 32; words 32..47 = 0x100..0x10F; done pulses exactly 4 cycles after the start edge.
- Multi-line ascending: src = 64, dst = 0, count = 4 → write addresses in order 0, 16, 32, 48; words 0..63 equal the original words 64..127; 4 write pulses.
- Overlap descending: words 0..47 = 0..47; src = 0, dst = 16, count = 3 → write addresses 48, 32, 16; words 16..63 = 0..47.
- Range/zero: src = 496, count = 2 → error pulse on the 2nd cycle after start, zero writes, done never high. count = 0 → done pulse, zero writes, no error.
- Robustness: during a 4-line copy, pulse start with different arguments → ignored, original copy completes. Separately, assert rst during the 2nd WRITE → we low next cycle, only lines 1–2 written, IDLE reached, no done.

Source files
------------

// File: rtl/mem_line_mover.sv
// rtl/mem_line_mover.sv - line-granular memmove engine driving the shared data memory line port
module mem_line_mover #(
    parameter int ADDR_W     = 9,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 16,
    parameter int CNT_W      = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            src_addr,
    input  logic [ADDR_W-1:0]            dst_addr,
    input  logic [CNT_W-1:0]             line_count,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [ADDR_W-1:0]            mem_address,
    output logic [LINE_WORDS*WORD_W-1:0] mem_data_to_write,
    output logic                         mem_write_enable,
    input  logic [LINE_WORDS*WORD_W-1:0] mem_data_from_memory
);

    localparam int LSH   = $clog2(LINE_WORDS);
    // Wide enough that base + span never wraps for any address/count combination.
    localparam int EXT_W = ((ADDR_W > CNT_W + LSH) ? ADDR_W : CNT_W + LSH) + 1;
    localparam logic [EXT_W-1:0]  MEM_WORDS = EXT_W'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(LINE_WORDS);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_WRITE, S_FIN} state_t;

    state_t                         state_q, state_d;
    logic [ADDR_W-1:0]              src_q, src_d;
    logic [ADDR_W-1:0]              dst_q, dst_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           desc_q, desc_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           error_q, error_d;
    logic                           we_q, we_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic [LINE_WORDS*WORD_W-1:0]   line_q, line_d;

    logic [EXT_W-1:0]               span, src_end, dst_end;
    logic [ADDR_W-1:0]              last_off, nxt_src, nxt_dst;

    assign span     = EXT_W'(cnt_q) << LSH;
    assign src_end  = EXT_W'(src_q) + span;
    assign dst_end  = EXT_W'(dst_q) + span;
    assign last_off = ADDR_W'(cnt_q - CNT_W'(1)) << LSH;
    assign nxt_src  = desc_q ? src_q - STEP : src_q + STEP;
    assign nxt_dst  = desc_q ? dst_q - STEP : dst_q + STEP;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        desc_d  = desc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        line_d  = line_q;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    cnt_d   = line_count;
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = S_FIN;
                end else if (src_end > MEM_WORDS || dst_end > MEM_WORDS) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    // Copying toward higher addresses must start from the top line so overlap is safe.
                    desc_d = dst_q > src_q;
                    if (dst_q > src_q) begin
                        src_d = src_q + last_off;
                        dst_d = dst_q + last_off;
                    end
                    addr_d  = src_d;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                line_d  = mem_data_from_memory;
                addr_d  = dst_q;
                we_d    = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                src_d = nxt_src;
                dst_d = nxt_dst;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    state_d = S_FIN;
                end else begin
                    addr_d  = nxt_src;
                    state_d = S_READ;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            desc_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            desc_q  <= desc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;
    assign mem_write_enable  = we_q;
    assign mem_address       = addr_q;
    assign mem_data_to_write = line_q;

endmodule

// File: tb/tb_mem_line_mover.sv
// tb/tb_mem_line_mover.sv - directed bench for mem_line_mover with a behavioural line memory
module tb_mem_line_mover;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [8:0]   src_addr, dst_addr;
    logic [5:0]   line_count;
    logic         busy, done, error;
    logic [8:0]   mem_address;
    logic [511:0] mem_data_to_write;
    logic         mem_write_enable;
    logic [511:0] mem_data_from_memory;

    logic [31:0]  mem [512];
    logic [8:0]   wr_q [$];
    logic         prev_we = 1'b0;
    int           n_consec = 0;
    logic         pre_req = 1'b0;
    int           pre_mode = 0;

    int vectors = 0;
    int miscompares = 0;

    mem_line_mover dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .line_count(line_count),
        .busy(busy), .done(done), .error(error),
        .mem_address(mem_address), .mem_data_to_write(mem_data_to_write),
        .mem_write_enable(mem_write_enable), .mem_data_from_memory(mem_data_from_memory)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int mode, input int i);
        case (mode)
            1:       return 32'(i);
            2:       return 32'h100 + 32'(i);
            default: return 32'h5A00_0000 + 32'(i);
        endcase
    endfunction

    always_comb begin
        mem_data_from_memory = '0;
        for (int k = 0; k < 16; k++)
            mem_data_from_memory[k*32 +: 32] = mem[mem_address + 9'(k)];
    end

    always @(posedge clk) begin
        if (pre_req) begin
            for (int i = 0; i < 512; i++) mem[i] <= pat(pre_mode, i);
        end else if (mem_write_enable) begin
            for (int k = 0; k < 16; k++)
                mem[mem_address + 9'(k)] <= mem_data_to_write[k*32 +: 32];
        end
        if (mem_write_enable) begin
            wr_q.push_back(mem_address);
            if (prev_we) n_consec <= n_consec + 1;
        end
        prev_we <= mem_write_enable;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int mode);
        @(negedge clk);
        pre_mode = mode;
        pre_req  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pre_req  = 1'b0;
    endtask

    // Issues one command, then watches win cycles; k counts edges after the start edge.
    task automatic run(input int s, input int d, input int c, input int win,
                       input int intr_k, input int rst_k,
                       output int done_k, output int n_done, output int err_k, output int n_err,
                       output int wbase, output logic we_ar, output logic busy_ar);
        done_k = -1; n_done = 0; err_k = -1; n_err = 0; we_ar = 1'bx; busy_ar = 1'bx;
        @(negedge clk);
        wbase      = wr_q.size();
        src_addr   = 9'(s);
        dst_addr   = 9'(d);
        line_count = 6'(c);
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= win; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin n_done++; if (done_k < 0) done_k = k; end
            if (error) begin n_err++; if (err_k < 0) err_k = k; end
            if (k == intr_k + 1) start = 1'b0;
            if (intr_k > 0 && k == intr_k) begin
                src_addr = 9'd0; dst_addr = 9'd16; line_count = 6'd1; start = 1'b1;
            end
            if (rst_k > 0 && k == rst_k + 1) begin
                we_ar = mem_write_enable; busy_ar = busy; rst = 1'b0;
            end
            if (rst_k > 0 && k == rst_k) rst = 1'b1;
        end
    endtask

    int dk, nd, ek, ne, wb;
    logic wa, ba;

    initial begin
        rst = 1'b1; start = 1'b1; src_addr = 9'd0; dst_addr = 9'd32; line_count = 6'd1;
        preload(0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_we", 64'(mem_write_enable), 64'd0);
        chk("rst_addr", 64'(mem_address), 64'd0);
        chk("rst_nowrite", 64'(wr_q.size()), 64'd0);
        chk("rst_mem32", 64'(mem[32]), 64'h5A00_0020);
        rst = 1'b0; start = 1'b0;

        preload(2);
        run(0, 32, 1, 8, 0, 0, dk, nd, ek, ne, wb, wa, ba);
        chk("single_done_k", 64'(dk), 64'd4);
        chk("single_n_done", 64'(nd), 64'd1);
        chk("single_n_err", 64'(ne), 64'd0);
        chk("single_writes", 64'(wr_q.size() - wb), 64'd1);
        chk("single_waddr", 64'(wr_q[wb]), 64'd32);
        for (int i = 0; i < 16; i++) chk($sformatf("single_w%0d", 32 + i), 64'(mem[32 + i]), 64'(32'h100 + i));
        chk("single_w48", 64'(mem[48]), 64'h130);

        preload(2);
        run(64, 0, 4, 14, 0, 0, dk, nd, ek, ne, wb, wa, ba);
        chk("asc_done_k", 64'(dk), 64'd10);
        chk("asc_writes", 64'(wr_q.size() - wb), 64'd4);
        for (int j = 0; j < 4; j++) chk($sformatf("asc_waddr%0d", j), 64'(wr_q[wb + j]), 64'(16 * j));
        for (int i = 0; i < 64; i++) chk($sformatf("asc_w%0d", i), 64'(mem[i]), 64'(32'h140 + i));

        preload(1);
        run(0, 16, 3, 12, 0, 0, dk, nd, ek, ne, wb, wa, ba);
        chk("ovl_done_k", 64'(dk), 64'd8);
        chk("ovl_writes", 64'(wr_q.size() - wb), 64'd3);
        for (int j = 0; j < 3; j++) chk($sformatf("ovl_waddr%0d", j), 64'(wr_q[wb + j]), 64'(48 - 16 * j));
        for (int i = 0; i < 64; i++) chk($sformatf("ovl_w%0d", i), 64'(mem[i]), 64'((i < 16) ? i : i - 16));

        preload(0);
        run(496, 0, 2, 8, 0, 0, dk, nd, ek, ne, wb, wa, ba);
        chk("range_err_k", 64'(ek), 64'd1);
        chk("range_n_err", 64'(ne), 64'd1);
        chk("range_n_done", 64'(nd), 64'd0);
        chk("range_writes", 64'(wr_q.size() - wb), 64'd0);

        run(0, 0, 0, 6, 0, 0, dk, nd, ek, ne, wb, wa, ba);
        chk("zero_done_k", 64'(dk), 64'd2);
        chk("zero_n_done", 64'(nd), 64'd1);
        chk("zero_n_err", 64'(ne), 64'd0);
        chk("zero_writes", 64'(wr_q.size() - wb), 64'd0);

        run(0, 496, 1, 8, 0, 0, dk, nd, ek, ne, wb, wa, ba);
        chk("top_done_k", 64'(dk), 64'd4);
        chk("top_n_err", 64'(ne), 64'd0);
        chk("top_waddr", 64'(wr_q[wb]), 64'd496);
        chk("top_w511", 64'(mem[511]), 64'h5A00_000F);

        preload(2);
        run(128, 320, 4, 14, 3, 0, dk, nd, ek, ne, wb, wa, ba);
        chk("intr_done_k", 64'(dk), 64'd10);
        chk("intr_n_done", 64'(nd), 64'd1);
        chk("intr_writes", 64'(wr_q.size() - wb), 64'd4);
        for (int j = 0; j < 4; j++) chk($sformatf("intr_waddr%0d", j), 64'(wr_q[wb + j]), 64'(368 - 16 * j));
        for (int i = 0; i < 64; i++) chk($sformatf("intr_w%0d", 320 + i), 64'(mem[320 + i]), 64'(32'h180 + i));
        chk("intr_w16", 64'(mem[16]), 64'h110);

        preload(2);
        run(256, 0, 4, 10, 0, 4, dk, nd, ek, ne, wb, wa, ba);
        chk("mrst_we", 64'(wa), 64'd0);
        chk("mrst_busy", 64'(ba), 64'd0);
        chk("mrst_n_done", 64'(nd), 64'd0);
        chk("mrst_n_err", 64'(ne), 64'd0);
        chk("mrst_writes", 64'(wr_q.size() - wb), 64'd2);
        chk("mrst_waddr0", 64'(wr_q[wb]), 64'd0);
        chk("mrst_waddr1", 64'(wr_q[wb + 1]), 64'd16);
        for (int i = 0; i < 32; i++) chk($sformatf("mrst_w%0d", i), 64'(mem[i]), 64'(32'h200 + i));
        chk("mrst_w32", 64'(mem[32]), 64'h120);

        chk("no_consecutive_we", 64'(n_consec), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
